// File: rtl/npi_ict_rd_mux_if.sv
// Signal bundle for npi_ict_rd_mux: NPI read FIFO, status-entry and client push sides.
// master = surrounding logic driving the router, slave = the router itself.
`timescale 1ns/1ps
interface npi_ict_rd_mux_if #(
    parameter int C_PIM_DATA_WIDTH = 64,
    parameter int C_NUM_PORTS      = 8,
    parameter int C_PORT_WIDTH     = 3,
    parameter int C_LEN_WIDTH      = 6
);
    logic [C_PIM_DATA_WIDTH-1:0] PIM_RdFIFO_Data;
    logic                        PIM_RdFIFO_Empty;
    logic [1:0]                  PIM_RdFIFO_Latency;
    logic                        PIM_RdFIFO_Pop;
    logic                        PIM_RdFIFO_Flush;
    logic                        rdsts_wren;
    logic [C_LEN_WIDTH-1:0]      rdsts_len;
    logic [C_PORT_WIDTH-1:0]     rdsts_nr;
    logic                        rdsts_afull;
    logic                        Abort;
    logic [C_NUM_PORTS-1:0]      Port_AFull;
    logic [C_NUM_PORTS-1:0]      Push;
    logic                        Push_Last;
    logic [C_PIM_DATA_WIDTH-1:0] Push_Data;
    logic                        Err;
    logic [15:0]                 npi_ict_dbg;

    modport master (
        output PIM_RdFIFO_Data, PIM_RdFIFO_Empty, PIM_RdFIFO_Latency,
        output rdsts_wren, rdsts_len, rdsts_nr, Abort, Port_AFull,
        input  PIM_RdFIFO_Pop, PIM_RdFIFO_Flush, rdsts_afull,
        input  Push, Push_Last, Push_Data, Err, npi_ict_dbg
    );

    modport slave (
        input  PIM_RdFIFO_Data, PIM_RdFIFO_Empty, PIM_RdFIFO_Latency,
        input  rdsts_wren, rdsts_len, rdsts_nr, Abort, Port_AFull,
        output PIM_RdFIFO_Pop, PIM_RdFIFO_Flush, rdsts_afull,
        output Push, Push_Last, Push_Data, Err, npi_ict_dbg
    );
endinterface

// File: rtl/npi_ict_rd_mux.sv
// Routes NPI read beats to client ports per queued {len, port} entry; Push trails Pop by latency+1 cycles.
// Pops stall while the NPI FIFO is empty or the owning port is almost-full; full status FIFO drops writes.
`timescale 1ns/1ps
module npi_ict_rd_mux #(
    parameter int C_PIM_DATA_WIDTH = 64,
    parameter int C_NUM_PORTS      = 8,
    parameter int C_PORT_WIDTH     = 3,
    parameter int C_LEN_WIDTH      = 6,
    parameter int C_STS_AWIDTH     = 3
) (
    input logic             Clk,
    input logic             Rst,
    npi_ict_rd_mux_if.slave bus
);
    localparam int DEPTH = 1 << C_STS_AWIDTH;
    localparam logic [C_STS_AWIDTH:0] AF_LVL = (C_STS_AWIDTH+1)'(DEPTH - 2);
    localparam logic [C_PORT_WIDTH:0] NP_LVL = (C_PORT_WIDTH+1)'(C_NUM_PORTS);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DATA = 2'd2, S_FLUSH = 2'd3} state_t;
    typedef struct packed {
        logic                    vld;
        logic                    last;
        logic [C_PORT_WIDTH-1:0] port;
    } stg_t;

    state_t                                 r_state;
    logic [C_LEN_WIDTH+C_PORT_WIDTH-1:0]    r_sts_mem [DEPTH];
    logic [C_STS_AWIDTH-1:0]                r_wr_ptr, r_rd_ptr;
    logic [C_STS_AWIDTH:0]                  r_sts_cnt;
    logic [C_LEN_WIDTH-1:0]                 r_cnt;
    logic [C_PORT_WIDTH-1:0]                r_port;
    logic                                   r_port_ok;
    stg_t                                   r_stg1, r_stg2;
    logic [C_NUM_PORTS-1:0]                 r_push;
    logic                                   r_push_last;
    logic [C_PIM_DATA_WIDTH-1:0]            r_push_data;
    logic                                   r_flush, r_err;

    logic                    w_sts_empty, w_sts_full;
    logic [C_LEN_WIDTH-1:0]  w_head_len;
    logic [C_PORT_WIDTH-1:0] w_head_nr;
    logic                    w_head_ok, w_last, w_pop, w_load;
    logic                    w_sts_wr, w_wr_drop, w_port_afull;
    stg_t                    w_stg0, w_sel;
    logic [C_NUM_PORTS-1:0]  w_push_dec;

    assign w_sts_empty = (r_sts_cnt == '0);
    assign w_sts_full  = r_sts_cnt[C_STS_AWIDTH];
    assign {w_head_len, w_head_nr} = r_sts_mem[r_rd_ptr];
    assign w_head_ok   = {1'b0, w_head_nr} < NP_LVL;
    assign w_last      = (r_cnt == C_LEN_WIDTH'(1));

    // Out-of-range ports never backpressure: their beats are popped and discarded.
    always_comb begin
        w_port_afull = 1'b0;
        for (int p = 0; p < C_NUM_PORTS; p++) begin
            if (r_port_ok && (r_port == C_PORT_WIDTH'(p))) w_port_afull = bus.Port_AFull[p];
        end
    end

    assign w_pop = (r_state == S_DATA) & ~bus.PIM_RdFIFO_Empty & ~w_port_afull & ~bus.Abort;
    // Loading the next entry on the last pop keeps back-to-back requests gapless.
    assign w_load    = ~bus.Abort & ((r_state == S_LOAD) | (w_pop & w_last & ~w_sts_empty));
    assign w_sts_wr  = bus.rdsts_wren & ~bus.Abort & (~w_sts_full | w_load);
    assign w_wr_drop = bus.rdsts_wren & ~bus.Abort & w_sts_full & ~w_load;

    assign w_stg0.vld  = w_pop & r_port_ok;
    assign w_stg0.last = w_last;
    assign w_stg0.port = r_port;

    always_comb begin
        case (bus.PIM_RdFIFO_Latency)
            2'd0:    w_sel = w_stg0;
            2'd1:    w_sel = r_stg1;
            default: w_sel = r_stg2;
        endcase
    end

    always_comb begin
        w_push_dec = '0;
        for (int p = 0; p < C_NUM_PORTS; p++) begin
            w_push_dec[p] = (w_sel.port == C_PORT_WIDTH'(p));
        end
    end

    always_ff @(posedge Clk) begin
        if (w_sts_wr) r_sts_mem[r_wr_ptr] <= {bus.rdsts_len, bus.rdsts_nr};
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_sts_cnt   <= '0;
            r_cnt       <= '0;
            r_port      <= '0;
            r_port_ok   <= 1'b0;
            r_stg1      <= '0;
            r_stg2      <= '0;
            r_push      <= '0;
            r_push_last <= 1'b0;
            r_push_data <= '0;
            r_flush     <= 1'b0;
            r_err       <= 1'b0;
        end else if (bus.Abort) begin
            r_state     <= S_FLUSH;
            r_flush     <= 1'b1;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_sts_cnt   <= '0;
            r_stg1.vld  <= 1'b0;
            r_stg2.vld  <= 1'b0;
            r_push      <= '0;
            r_push_last <= 1'b0;
        end else begin
            r_flush     <= 1'b0;
            r_stg1      <= w_stg0;
            r_stg2      <= r_stg1;
            r_push      <= w_sel.vld ? w_push_dec : '0;
            r_push_last <= w_sel.vld & w_sel.last;
            if (w_sel.vld) r_push_data <= bus.PIM_RdFIFO_Data;

            if (w_sts_wr) r_wr_ptr <= r_wr_ptr + C_STS_AWIDTH'(1);
            if (w_load)   r_rd_ptr <= r_rd_ptr + C_STS_AWIDTH'(1);
            case ({w_sts_wr, w_load})
                2'b10:   r_sts_cnt <= r_sts_cnt + (C_STS_AWIDTH+1)'(1);
                2'b01:   r_sts_cnt <= r_sts_cnt - (C_STS_AWIDTH+1)'(1);
                default: r_sts_cnt <= r_sts_cnt;
            endcase
            if (w_wr_drop) r_err <= 1'b1;

            case (r_state)
                S_IDLE:  if (!w_sts_empty) r_state <= S_LOAD;
                S_LOAD:  r_state <= S_DATA;
                S_DATA: begin
                    if (w_pop) begin
                        r_cnt <= r_cnt - C_LEN_WIDTH'(1);
                        if (w_last) r_state <= S_IDLE;
                    end
                end
                S_FLUSH: r_state <= S_IDLE;
            endcase

            if (w_load) begin
                r_cnt     <= w_head_len;
                r_port    <= w_head_nr;
                r_port_ok <= w_head_ok;
                if (w_head_len == '0) begin
                    r_err   <= 1'b1;
                    r_state <= S_IDLE;
                end else begin
                    if (!w_head_ok) r_err <= 1'b1;
                    r_state <= S_DATA;
                end
            end
        end
    end

    assign bus.PIM_RdFIFO_Pop   = w_pop;
    assign bus.PIM_RdFIFO_Flush = r_flush;
    assign bus.rdsts_afull      = (r_sts_cnt >= AF_LVL);
    assign bus.Push             = r_push;
    assign bus.Push_Last        = r_push_last;
    assign bus.Push_Data        = r_push_data;
    assign bus.Err              = r_err;
    assign bus.npi_ict_dbg      = {4'(r_cnt), 4'(r_port), r_state, w_sts_empty,
                                   bus.rdsts_afull, w_pop, r_err, 2'b00};
endmodule
